// File: rtl/eeprom_access_arbiter_if.sv
// rtl/eeprom_access_arbiter_if.sv - requester and SPI command engine bus for the EEPROM access arbiter
interface eeprom_access_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req0_done;
    logic        req0_err;

    logic        req1_valid;
    logic [7:0]  req1_addr;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        req1_done;
    logic        req1_err;

    logic        eng_valid;
    logic [7:0]  eng_op;
    logic [7:0]  eng_addr;
    logic [15:0] eng_data;
    logic        eng_ready;
    logic        eng_done;
    logic [7:0]  eng_status;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready, req0_done, req0_err,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready, req1_done, req1_err,
        output eng_valid, eng_op, eng_addr, eng_data,
        input  eng_ready, eng_done, eng_status
    );

    // Requester / engine side
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready, req0_done, req0_err,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready, req1_done, req1_err,
        input  eng_valid, eng_op, eng_addr, eng_data,
        output eng_ready, eng_done, eng_status
    );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// rtl/eeprom_access_arbiter.sv - round-robin arbiter sequencing WREN/WRITE/RDSR-poll EEPROM writes
module eeprom_access_arbiter #(
    parameter int unsigned POLL_LIMIT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    eeprom_access_arbiter_if.slave bus,
    output logic                   busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_WREN_WAIT,
        S_WRITE,
        S_WRITE_WAIT,
        S_POLL,
        S_POLL_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0]  OP_WREN  = 8'h06;
    localparam logic [7:0]  OP_WRITE = 8'h02;
    localparam logic [7:0]  OP_RDSR  = 8'h05;
    localparam logic [16:0] POLL_LIMIT_W = 17'(POLL_LIMIT);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        eng_valid_q, eng_valid_d;
    logic [7:0]  eng_op_q, eng_op_d;
    logic [7:0]  eng_addr_q, eng_addr_d;
    logic [15:0] eng_data_q, eng_data_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d;

    logic        grant;
    logic        accepted;
    logic [16:0] poll_next;
    logic        status_unused;

    // Only the WIP bit of the status register matters here.
    assign status_unused = ^bus.eng_status[7:1];

    // Next-state, arbitration and command sequencing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        poll_cnt_d   = poll_cnt_q;
        eng_valid_d  = eng_valid_q;
        eng_op_d     = eng_op_q;
        eng_addr_d   = eng_addr_q;
        eng_data_d   = eng_data_q;
        ready_d      = 2'b00;
        done_d       = 2'b00;
        err_d        = 2'b00;

        accepted  = eng_valid_q & bus.eng_ready;
        poll_next = {1'b0, poll_cnt_q} + 17'd1;
        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        grant     = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid | bus.req1_valid) begin
                    state_d      = S_WREN;
                    owner_d      = grant;
                    last_grant_d = grant;
                    ready_d      = grant ? 2'b10 : 2'b01;
                    eng_addr_d   = grant ? bus.req1_addr : bus.req0_addr;
                    eng_data_d   = grant ? bus.req1_data : bus.req0_data;
                    eng_valid_d  = 1'b1;
                    eng_op_d     = OP_WREN;
                end
            end
            S_WREN: begin
                if (accepted) begin
                    eng_valid_d = 1'b0;
                    state_d     = S_WREN_WAIT;
                end
            end
            S_WREN_WAIT: begin
                if (bus.eng_done) begin
                    eng_valid_d = 1'b1;
                    eng_op_d    = OP_WRITE;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accepted) begin
                    eng_valid_d = 1'b0;
                    state_d     = S_WRITE_WAIT;
                end
            end
            S_WRITE_WAIT: begin
                if (bus.eng_done) begin
                    poll_cnt_d  = 16'd0;
                    eng_valid_d = 1'b1;
                    eng_op_d    = OP_RDSR;
                    state_d     = S_POLL;
                end
            end
            S_POLL: begin
                if (accepted) begin
                    eng_valid_d = 1'b0;
                    state_d     = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (bus.eng_done) begin
                    // poll_next never exceeds POLL_LIMIT, so the low 16 bits cannot wrap.
                    poll_cnt_d = poll_next[15:0];
                    if (!bus.eng_status[0]) begin
                        state_d = S_RESP;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                    end else if (poll_next == POLL_LIMIT_W) begin
                        state_d = S_RESP;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                        err_d   = owner_q ? 2'b10 : 2'b01;
                    end else begin
                        eng_valid_d = 1'b1;
                        state_d     = S_POLL;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            poll_cnt_q   <= 16'd0;
            eng_valid_q  <= 1'b0;
            eng_op_q     <= 8'h00;
            eng_addr_q   <= 8'h00;
            eng_data_q   <= 16'h0000;
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            poll_cnt_q   <= poll_cnt_d;
            eng_valid_q  <= eng_valid_d;
            eng_op_q     <= eng_op_d;
            eng_addr_q   <= eng_addr_d;
            eng_data_q   <= eng_data_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_err   = err_q[0];
    assign bus.req1_err   = err_q[1];
    assign bus.eng_valid  = eng_valid_q;
    assign bus.eng_op     = eng_op_q;
    assign bus.eng_addr   = eng_addr_q;
    assign bus.eng_data   = eng_data_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// tb/tb_eeprom_access_arbiter.sv - scoreboard bench for eeprom_access_arbiter with an SPI engine model
module tb_eeprom_access_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    eeprom_access_arbiter_if bus();

    eeprom_access_arbiter #(.POLL_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        logic who;
        logic err;
    } done_t;

    typedef struct {
        logic        who;
        logic [7:0]  addr;
        logic [15:0] data;
        int          wip_ones;
        bit          bp;
        int          exp_polls;
        logic        exp_err;
    } vec_t;

    cmd_t  exp_cmd_q[$];
    done_t exp_done_q[$];
    logic  exp_grant_q[$];
    logic  wip_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    int          req_set[2];
    int          req_ack[2];
    logic [7:0]  req_addr[2];
    logic [15:0] req_data[2];
    int          eng_lat = 2;
    bit          bp_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_txn(input logic who, input logic [7:0] a, input logic [15:0] d,
                            input int polls, input logic err);
        exp_grant_q.push_back(who);
        exp_cmd_q.push_back('{8'h06, a, d});
        exp_cmd_q.push_back('{8'h02, a, d});
        for (int i = 0; i < polls; i++) exp_cmd_q.push_back('{8'h05, a, d});
        exp_done_q.push_back('{who, err});
    endtask

    task automatic start_req(input int who, input logic [7:0] a, input logic [15:0] d);
        req_addr[who] = a;
        req_data[who] = d;
        req_set[who]  = req_set[who] + 1;
    endtask

    task automatic wait_txns();
        for (int i = 0; i < 3000; i++) begin
            if (exp_done_q.size() == 0 && exp_grant_q.size() == 0) break;
            @(posedge clk);
        end
        check("txn_timeout", exp_done_q.size(), 0);
        exp_done_q.delete();
        exp_grant_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("cmds_consumed", exp_cmd_q.size(), 0);
        exp_cmd_q.delete();
        check("idle_after_txn", busy, 0);
    endtask

    task automatic check_reset_values();
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req0_done", bus.req0_done, 0);
        check("rst_req0_err", bus.req0_err, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_req1_done", bus.req1_done, 0);
        check("rst_req1_err", bus.req1_err, 0);
        check("rst_eng_valid", bus.eng_valid, 0);
        check("rst_eng_op", bus.eng_op, 8'h00);
        check("rst_eng_addr", bus.eng_addr, 8'h00);
        check("rst_eng_data", bus.eng_data, 16'h0000);
        check("rst_busy", busy, 0);
    endtask

    // Requester drivers, SPI engine model and output monitor.
    initial begin : model
        bit          acc, rdy0, rdy1, saw_valid, was_stalled, prev_eng_done, expect_idle, eng_busy;
        logic [7:0]  s_op, cur_op, prev_op;
        int          lat, hold;
        cmd_t        c;
        done_t       d;
        logic        g, wip;
        req_set[0] = 0; req_set[1] = 0; req_ack[0] = 0; req_ack[1] = 0;
        req_addr[0] = 0; req_addr[1] = 0; req_data[0] = 0; req_data[1] = 0;
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.eng_ready = 1; bus.eng_done = 0; bus.eng_status = 8'h00;
        was_stalled = 0; prev_eng_done = 0; expect_idle = 0; eng_busy = 0;
        lat = 0; hold = 0; cur_op = 0; prev_op = 0;
        forever begin
            @(negedge clk);
            acc       = bus.eng_valid && bus.eng_ready;
            rdy0      = bus.req0_ready;
            rdy1      = bus.req1_ready;
            saw_valid = bus.eng_valid;
            s_op      = bus.eng_op;
            if (!rst) begin
                if (expect_idle) begin
                    check("idle_after_done", busy, 0);
                    expect_idle = 0;
                end
                if (was_stalled) begin
                    check("bp_valid_held", bus.eng_valid, 1);
                    check("bp_op_stable", bus.eng_op, prev_op);
                end
                if (eng_busy) check("no_valid_in_wait", bus.eng_valid, 0);
                check("err0_only_with_done", bus.req0_err & ~bus.req0_done, 0);
                check("err1_only_with_done", bus.req1_err & ~bus.req1_done, 0);
                if (rdy0 || rdy1) begin
                    check("ready_exclusive", rdy0 & rdy1, 0);
                    check("ready_not_with_done", bus.req0_done | bus.req1_done, 0);
                    check("wren_with_ready", bus.eng_valid, 1);
                    check("wren_op_with_ready", bus.eng_op, 8'h06);
                    check("busy_with_ready", busy, 1);
                    if (exp_grant_q.size() == 0) fail_now("unexpected_grant");
                    else begin
                        g = exp_grant_q.pop_front();
                        check("grant_owner", rdy1, g);
                    end
                end
                if (acc) begin
                    if (exp_cmd_q.size() == 0) fail_now("unexpected_command");
                    else begin
                        c = exp_cmd_q.pop_front();
                        check("cmd_op", bus.eng_op, c.op);
                        check("cmd_addr", bus.eng_addr, c.addr);
                        check("cmd_data", bus.eng_data, c.data);
                    end
                end
                if (bus.req0_done || bus.req1_done) begin
                    check("done_exclusive", bus.req0_done & bus.req1_done, 0);
                    check("done_after_eng_done", prev_eng_done, 1);
                    check("valid_low_at_done", bus.eng_valid, 0);
                    if (exp_done_q.size() == 0) fail_now("unexpected_done");
                    else begin
                        d = exp_done_q.pop_front();
                        check("done_owner", bus.req1_done, d.who);
                        check("done_err", d.who ? bus.req1_err : bus.req0_err, d.err);
                    end
                    expect_idle = 1;
                end
            end
            was_stalled   = bus.eng_valid && !bus.eng_ready && !rst;
            prev_op       = bus.eng_op;
            prev_eng_done = bus.eng_done;

            @(posedge clk);
            #1;
            if (rdy0) req_ack[0] = req_ack[0] + 1;
            if (rdy1) req_ack[1] = req_ack[1] + 1;
            bus.req0_valid = (req_set[0] != req_ack[0]);
            bus.req0_addr  = req_addr[0];
            bus.req0_data  = req_data[0];
            bus.req1_valid = (req_set[1] != req_ack[1]);
            bus.req1_addr  = req_addr[1];
            bus.req1_data  = req_data[1];
            bus.eng_done   = 0;
            if (acc) begin
                eng_busy = 1;
                lat      = eng_lat;
                cur_op   = s_op;
                hold     = 0;
            end else if (eng_busy) begin
                lat = lat - 1;
                if (lat == 0) begin
                    eng_busy     = 0;
                    bus.eng_done = 1;
                    if (cur_op == 8'h05) begin
                        wip = (wip_q.size() > 0) ? wip_q.pop_front() : 1'b0;
                        bus.eng_status = {7'h2A, wip};
                    end else begin
                        bus.eng_status = 8'hA5;
                    end
                end
            end else if (saw_valid) begin
                hold = hold + 1;
            end
            bus.eng_ready = !eng_busy && (!bp_mode || hold >= 10);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[7];
        bit   saw_stray;
        vecs[0] = '{1'b0, 8'h3C, 16'hBEEF, 0, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b1, 8'h81, 16'h1234, 3, 1'b0, 4, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 16'hFFFF, 4, 1'b0, 4, 1'b1};
        vecs[3] = '{1'b1, 8'hFF, 16'h0001, 1, 1'b1, 2, 1'b0};
        vecs[4] = '{1'b0, 8'h55, 16'hA5A5, 7, 1'b0, 4, 1'b1};
        vecs[5] = '{1'b1, 8'hC3, 16'h8000, 2, 1'b1, 3, 1'b0};
        vecs[6] = '{1'b0, 8'h5A, 16'h00FF, 9, 1'b1, 4, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Tie from reset: requester 0 first, then alternate.
        for (int r = 0; r < 2; r++) begin
            push_txn(1'b0, 8'h10 + 8'(r), 16'h1000 + 16'(r), 1, 1'b0);
            push_txn(1'b1, 8'h20 + 8'(r), 16'h2000 + 16'(r), 1, 1'b0);
            start_req(0, 8'h10 + 8'(r), 16'h1000 + 16'(r));
            start_req(1, 8'h20 + 8'(r), 16'h2000 + 16'(r));
            wait_txns();
        end

        for (int i = 0; i < 7; i++) begin
            wip_q.delete();
            for (int k = 0; k < vecs[i].wip_ones; k++) wip_q.push_back(1'b1);
            bp_mode = vecs[i].bp;
            push_txn(vecs[i].who, vecs[i].addr, vecs[i].data, vecs[i].exp_polls, vecs[i].exp_err);
            start_req(int'(vecs[i].who), vecs[i].addr, vecs[i].data);
            wait_txns();
        end
        bp_mode = 1'b0;
        wip_q.delete();

        // Reset while waiting for the WRITE to finish.
        eng_lat = 8;
        exp_grant_q.push_back(1'b0);
        exp_cmd_q.push_back('{8'h06, 8'h77, 16'h4242});
        exp_cmd_q.push_back('{8'h02, 8'h77, 16'h4242});
        start_req(0, 8'h77, 16'h4242);
        for (int i = 0; i < 200; i++) begin
            if (exp_cmd_q.size() == 0) break;
            @(posedge clk);
        end
        check("reach_write_wait", exp_cmd_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        saw_stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw_stray = saw_stray | bus.eng_done;
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", bus.eng_valid, 0);
        end
        check("stray_eng_done_seen", saw_stray, 1);
        eng_lat = 2;

        // After reset the tie goes to requester 0 again and starts at WREN.
        push_txn(1'b0, 8'hE1, 16'h0F0F, 1, 1'b0);
        push_txn(1'b1, 8'hE2, 16'hF0F0, 2, 1'b0);
        wip_q.push_back(1'b0);
        wip_q.push_back(1'b1);
        start_req(0, 8'hE1, 16'h0F0F);
        start_req(1, 8'hE2, 16'hF0F0);
        wait_txns();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/eeprom_access_arbiter.md
# eeprom_access_arbiter

Shares the single SPI EEPROM command engine between two internal requesters and sequences each write as a complete transaction. Each write is WREN, then WRITE (8-bit address, 16-bit data), then RDSR polling until the write-in-progress bit clears. The block sits between the configuration/calibration logic and the SPI engine. It grants requesters round-robin, serializes all EEPROM traffic, and reports completion or timeout to the winning requester.

## Interface
Parameters:
- POLL_LIMIT, 1000: maximum RDSR polls per write before timeout; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 write request; held until req0_ready.
- req0_addr  in  8  requester 0 EEPROM byte address.
- req0_data  in  16  requester 0 write data, MSB first on the wire.
- req0_ready  out  1  one-cycle pulse; request captured.
- req0_done  out  1  one-cycle pulse; transaction finished.
- req0_err  out  1  valid with req0_done; 1 = poll timeout.
- req1_valid, req1_addr, req1_data, req1_ready, req1_done, req1_err: same as requester 0, for requester 1.
- eng_valid  out  1  command to engine; held until accepted.
- eng_op  out  8  opcode: WREN 8'h06, WRITE 8'h02, RDSR 8'h05.
- eng_addr  out  8  address; meaningful for WRITE only.
- eng_data  out  16  data; meaningful for WRITE only.
- eng_ready  in  1  engine idle; command accepted when eng_valid & eng_ready.
- eng_done  in  1  one-cycle pulse; engine finished current command.
- eng_status  in  8  RDSR result; valid with eng_done; bit 0 = WIP.
- busy  out  1  high in every state except IDLE.

## Operation
States and transitions:
- IDLE → WREN when either reqN_valid is high. In that cycle, pulse the granted reqN_ready, capture addr/data, and record the owner.
- WREN: drive eng_valid with eng_op=06. On acceptance → WREN_WAIT.
- WREN_WAIT: on eng_done → WRITE.
- WRITE: drive eng_op=02 with the captured addr/data. On acceptance → WRITE_WAIT.
- WRITE_WAIT: on eng_done, clear poll_cnt → POLL.
- POLL: drive eng_op=05. On acceptance → POLL_WAIT.
- POLL_WAIT: on eng_done, poll_cnt increments, then:
  - WIP=0 → RESP with err=0.
  - WIP=1 and poll_cnt+1 == POLL_LIMIT → RESP with err=1.
  - otherwise → POLL.
- RESP: pulse owner's done, with err set as decided → IDLE.

Arbitration and capture:
- Round-robin. last_grant resets to 1, so requester 0 wins the first tie. When both request, grant the one not equal to last_grant. A lone requester is always granted.
- A request that loses arbitration stays pending and is not captured. It is granted on the next IDLE.
- Captured addr/data are frozen for the whole transaction. Requester inputs are ignored outside IDLE.

Other rules:
- eng_done outside a *_WAIT state is ignored.
- eng_status is sampled only in POLL_WAIT.
- poll_cnt width is 16 bits and never wraps: the timeout check precedes increment overflow.
- eng_addr and eng_data hold their captured values in all states. They are 0 after reset.

## Timing
- Reset values: req*_ready=0, req*_done=0, req*_err=0, eng_valid=0, eng_op=8'h00, eng_addr=0, eng_data=0, busy=0, state=IDLE, last_grant=1, poll_cnt=0.
- Reset mid-transaction returns to IDLE immediately. No done pulse is issued. The engine is reset by the same rst.
- Accept at cycle T (IDLE, valid high): reqN_ready=1 at T+1, eng_valid for WREN at T+1, busy=1 from T+1.
- eng_valid deasserts the cycle after acceptance and is never asserted in *_WAIT, RESP or IDLE.
- Fast path: reqN_done rises one cycle after the eng_done that reports WIP=0. The next IDLE follows one cycle later. Minimum gap from one done pulse to the next acceptance is 1 cycle.
- reqN_done and reqN_ready never assert in the same cycle. Outputs for the non-owner stay 0.
- Simultaneous eng_done and eng_ready are legal; each is evaluated only in its own state.

## Test plan
- Single write: req0 addr=8'h3C, data=16'hBEEF. Engine answers WIP=0 on the first RDSR → eng_op sequence 06,02,05; eng_addr=3C, eng_data=BEEF on WRITE; one req0_done with req0_err=0; req1 outputs silent.
- Contention: req0 and req1 valid in the same cycle from reset → req0 served first, then req1; repeat both → grant alternates 0,1,0,1.
- Polling: engine returns WIP=1 three times, then 0 → exactly four RDSR commands; done err=0.
- Timeout: POLL_LIMIT=4, WIP always 1 → exactly four RDSR commands; done with err=1; block back in IDLE; next request is accepted normally.
- Backpressure: hold eng_ready=0 for 10 cycles in each command state → eng_valid stays high and eng_op stable; no command dropped or duplicated.
- Mid-operation reset: assert rst for 1 cycle during WRITE_WAIT → all outputs at reset values next cycle; no done pulse; a later eng_done is ignored; next request starts at WREN.
